// File: rtl/board_draw_ctrl.sv
// Board redraw sequencer: walks the 16 tiles of a snapshotted board and
// drives a glyph drawer for each non-blank tile, one burst per tile.
module board_draw_ctrl #(
    parameter logic [7:0] X0          = 8'd28,
    parameter logic [6:0] Y0          = 7'd8,
    parameter logic [4:0] PITCH       = 5'd26,
    parameter logic [6:0] TILE_CYCLES = 7'd81
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] board,
    output logic [7:0]  xBase,
    output logic [6:0]  yBase,
    output logic [3:0]  glyphSel,
    output logic        glyphEnable,
    output logic        glyphResetn,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        DRAW,
        NEXT,
        DONE
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [63:0] snap;
    logic [3:0]  idx;
    logic [6:0]  count;

    logic        loadSnap;
    logic        clrIdx;
    logic        incIdx;
    logic        clrCount;
    logic        incCount;

    logic [3:0]  tileVal;
    logic        tileBlank;
    logic        lastCount;
    logic        lastTile;
    logic [7:0]  colOff;
    logic [6:0]  rowOff;

    assign tileVal   = snap[{idx, 2'b00} +: 4];
    assign tileBlank = (tileVal == 4'd0);
    assign lastCount = (count == TILE_CYCLES - 7'd1);
    assign lastTile  = (idx == 4'd15);

    // Tile origin follows the current index; col = idx[1:0], row = idx[3:2].
    assign colOff = 8'(idx[1:0]) * 8'(PITCH);
    assign rowOff = 7'(idx[3:2]) * 7'(PITCH);
    assign xBase  = X0 + colOff;
    assign yBase  = Y0 + rowOff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            snap  <= '0;
            idx   <= '0;
            count <= '0;
        end else begin
            state <= stateNext;
            if (loadSnap) begin
                snap <= board;
            end
            if (clrIdx) begin
                idx <= '0;
            end else if (incIdx) begin
                idx <= idx + 4'd1;
            end
            if (clrCount) begin
                count <= '0;
            end else if (incCount) begin
                count <= count + 7'd1;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        loadSnap    = 1'b0;
        clrIdx      = 1'b0;
        incIdx      = 1'b0;
        clrCount    = 1'b0;
        incCount    = 1'b0;
        glyphSel    = 4'd0;
        glyphEnable = 1'b0;
        glyphResetn = 1'b1;
        plot        = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                loadSnap  = 1'b1;
                clrIdx    = 1'b1;
                stateNext = CLEAR;
            end
            CLEAR: begin
                glyphResetn = 1'b0;
                glyphSel    = tileVal;
                clrCount    = 1'b1;
                stateNext   = tileBlank ? NEXT : DRAW;
            end
            DRAW: begin
                glyphSel    = tileVal;
                glyphEnable = 1'b1;
                plot        = 1'b1;
                incCount    = 1'b1;
                if (lastCount) begin
                    stateNext = NEXT;
                end
            end
            NEXT: begin
                glyphSel = tileVal;
                if (lastTile) begin
                    stateNext = DONE;
                end else begin
                    incIdx    = 1'b1;
                    stateNext = CLEAR;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
